sdpram_pipe: RTL

Parametrised simple dual-port RAM: one write port (A), one read port (B), one clock. It is the configurable successor to the team's fixed 32x48 LUT-RAM buffer and adds:
- configurable width and depth
- byte-enable writes
- a selectable read pipeline depth with an output valid flag
- a selectable same-address collision policy
- out-of-range address flagging

It sits between producer and consumer datapaths as a scratch/line buffer. Storage is an inferred memory array with no vendor macro.

---
 rtl/sdpram_pipe.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sdpram_pipe.sv
// sdpram_pipe: simple dual-port RAM with one write port (A) and one read port (B)
// on a single clock. It has byte-lane write enables, a read pipeline depth of
// 0..3 with an output valid flag, a selectable same-address collision policy,
// and flags for out-of-range addresses.
// Storage is an inferred array. Its contents are never cleared by rst and
// power up as all-zero, which is the configuration default of inferred RAM.

module sdpram_pipe #(
  parameter int                DATA_W       = 32,
  parameter int                BYTE_W       = 8,
  parameter int                DEPTH        = 48,
  parameter int                ADDR_W       = $clog2(DEPTH),
  parameter int                READ_LATENCY = 1,
  parameter string             WRITE_MODE   = "read_first",
  parameter logic [DATA_W-1:0] RST_VAL      = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [DATA_W/BYTE_W-1:0]   wea,
  input  logic [ADDR_W-1:0]          addra,
  input  logic [DATA_W-1:0]          dina,
  input  logic                       enb,
  input  logic [ADDR_W-1:0]          addrb,
  output logic [DATA_W-1:0]          doutb,
  output logic                       doutb_valid,
  output logic [1:0]                 addr_err
);

  localparam int NBYTE       = DATA_W / BYTE_W;
  localparam bit WRITE_FIRST = (WRITE_MODE == "write_first");

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_bad_latency
    $error("sdpram_pipe: READ_LATENCY must be in 0..3");
  end

  if ((DATA_W % BYTE_W) != 0) begin : g_bad_lanes
    $error("sdpram_pipe: DATA_W must be a multiple of BYTE_W");
  end

  if (WRITE_MODE != "read_first" && WRITE_MODE != "write_first") begin : g_bad_mode
    $error("sdpram_pipe: WRITE_MODE must be \"read_first\" or \"write_first\"");
  end

  if (DEPTH < 2 || (64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_depth
    $error("sdpram_pipe: DEPTH must be >= 2 and addressable by ADDR_W bits");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Overlay the enabled byte lanes of new_word onto old_word.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NBYTE-1:0]  lane_en
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < NBYTE; i++) begin
      if (lane_en[i]) begin
        merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end else begin
        merged[i*BYTE_W +: BYTE_W] = old_word[i*BYTE_W +: BYTE_W];
      end
    end
    return merged;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage and decode
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              wr_any_s;      // write attempted (any lane enabled)
  logic              wr_inrange_s;
  logic              wr_en_s;       // write actually lands in memory
  logic              rd_inrange_s;
  logic              rd_req_s;      // read request accepted this edge
  logic              collision_s;   // same in-range word written and read
  logic [DATA_W-1:0] rd_word_s;     // stored word (pre-write) or RST_VAL
  logic [DATA_W-1:0] fwd_word_s;    // stored word with this cycle's write merged
  logic [DATA_W-1:0] rd_data_s;     // read result under the collision policy
  logic [1:0]        err_r;

  // Address range decode, request qualification and collision forwarding.
  always_comb begin
    wr_any_s     = 1'b0;
    wr_inrange_s = 1'b0;
    wr_en_s      = 1'b0;
    rd_inrange_s = 1'b0;
    rd_req_s     = 1'b0;
    collision_s  = 1'b0;
    rd_word_s    = RST_VAL;
    fwd_word_s   = RST_VAL;
    rd_data_s    = RST_VAL;

    wr_any_s     = ena & (|wea);
    wr_inrange_s = (32'(addra) < 32'(DEPTH));
    wr_en_s      = wr_any_s & wr_inrange_s & ~rst;
    rd_inrange_s = (32'(addrb) < 32'(DEPTH));
    rd_req_s     = enb & ~rst;
    collision_s  = wr_any_s & wr_inrange_s & (addra == addrb);

    if (rd_inrange_s) begin
      rd_word_s = mem_r[addrb];
    end else begin
      rd_word_s = RST_VAL;
    end

    fwd_word_s = merge_lanes(rd_word_s, dina, wea);

    if (WRITE_FIRST && collision_s) begin
      rd_data_s = fwd_word_s;
    end else begin
      rd_data_s = rd_word_s;
    end
  end

  // Byte-lane memory write; only in-range, enabled lanes outside reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTE; i++) begin
      if (wr_en_s && wea[i]) begin
        mem_r[addra][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // One-cycle address error pulses: bit0 for write, bit1 for read.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 2'b00;
    end else begin
      err_r <= {enb & ~rd_inrange_s, wr_any_s & ~wr_inrange_s};
    end
  end

  assign addr_err = err_r;

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  if (READ_LATENCY == 0) begin : g_async
    // Combinational read: no output registers, reset only touches addr_err.
    assign doutb       = rd_data_s;
    assign doutb_valid = rd_req_s;
  end else begin : g_pipe
    logic [READ_LATENCY-1:0] vld_r;
    logic [DATA_W-1:0]       dat_r [READ_LATENCY];

    // Shift accepted requests toward the output. A stage's data loads only
    // when a valid word arrives, so the last stage holds its value between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_r <= '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
          dat_r[i] <= RST_VAL;
        end
      end else begin
        vld_r[0] <= rd_req_s;
        if (rd_req_s) begin
          dat_r[0] <= rd_data_s;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
          vld_r[i] <= vld_r[i-1];
          if (vld_r[i-1]) begin
            dat_r[i] <= dat_r[i-1];
          end
        end
      end
    end

    assign doutb       = dat_r[READ_LATENCY-1];
    assign doutb_valid = vld_r[READ_LATENCY-1];
  end

endmodule
